// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_state_e     : owner FSM encoding (IDLE / OWN0 / OWN1)
//   MAX_BURST_DEFAULT : default burst limit before a forced handover
//   BURST_CNT_W       : burst counter width (holds up to 15)
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_state_e;

   localparam int MAX_BURST_DEFAULT = 4;
   localparam int BURST_CNT_W       = 4;

endpackage

// File: rtl/arb_burst_counter.sv
// Burst counter for the data-memory arbiter.
// Counts granted accesses made by the current owner. It saturates at
// MAX_BURST and returns to zero whenever the owner state changes.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clear_i : owner state changes this cycle
//   inc_i   : one access is granted this cycle
//   cnt_o   : grants already made in this ownership (registered)
//   limit_o : this cycle's grant is the MAX_BURST-th or a later one
module arb_burst_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   inc_i,
   output logic [BURST_CNT_W-1:0] cnt_o,
   output logic                   limit_o
);

   localparam logic [BURST_CNT_W-1:0] CNT_LAST = BURST_CNT_W'(MAX_BURST - 1);
   localparam logic [BURST_CNT_W-1:0] CNT_SAT  = BURST_CNT_W'(MAX_BURST);

   logic [BURST_CNT_W-1:0] cnt_q, cnt_d;

   // Once saturated, every further grant is still "at the limit", so a
   // late request from the other master is served immediately.
   assign limit_o = inc_i && (cnt_q >= CNT_LAST);
   assign cnt_o   = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < CNT_SAT)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a data memory with synchronous write and
// combinational read. The owner FSM grants one master per cycle. A tie in
// IDLE goes to the master that was not granted last. An owner is forced to
// hand over after MAX_BURST consecutive grants if the other master waits.
// Read data is registered and signalled by a one-cycle rvalid pulse.
//   clk, rst (async, active-low)
//   mX_req/we/addr/wdata   : master X request inputs
//   mX_gnt                 : master X access is performed this cycle
//   mX_rvalid/rdata        : master X read response (one cycle after grant)
//   mem_a/mem_we/mem_wd    : memory request, zero when nothing is granted
//   mem_rd                 : memory read data
//   state_o/burst_cnt_o    : debug view of owner FSM and burst counter
//
// Handshake: a request is held on mX_req until mX_gnt is seen high. Each
// cycle with mX_gnt high performs exactly one access. A granted read
// returns its data with mX_rvalid high on the following cycle only.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEFAULT,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0_req,
   input  logic                   m0_we,
   input  logic [AW-1:0]          m0_addr,
   input  logic [DW-1:0]          m0_wdata,
   input  logic                   m1_req,
   input  logic                   m1_we,
   input  logic [AW-1:0]          m1_addr,
   input  logic [DW-1:0]          m1_wdata,
   output logic                   m0_gnt,
   output logic                   m1_gnt,
   output logic                   m0_rvalid,
   output logic                   m1_rvalid,
   output logic [DW-1:0]          m0_rdata,
   output logic [DW-1:0]          m1_rdata,
   output logic [AW-1:0]          mem_a,
   output logic                   mem_we,
   output logic [DW-1:0]          mem_wd,
   input  logic [DW-1:0]          mem_rd,
   output owner_state_e           state_o,
   output logic [BURST_CNT_W-1:0] burst_cnt_o
);

   owner_state_e   state_q, state_d;
   logic           last_owner_q, last_owner_d;
   logic           rvalid0_q, rvalid1_q;
   logic [DW-1:0]  rdata0_q, rdata1_q;
   logic           cnt_clear, cnt_limit;

   // A grant needs both ownership and a live request. This means a request
   // dropped in the cycle the state moves to its OWN state gets nothing.
   assign m0_gnt = (state_q == OWN0) && m0_req;
   assign m1_gnt = (state_q == OWN1) && m1_req;

   always_comb begin
      mem_a  = '0;
      mem_we = 1'b0;
      mem_wd = '0;
      if (m0_gnt) begin
         mem_a  = m0_addr;
         mem_we = m0_we;
         mem_wd = m0_wdata;
      end else if (m1_gnt) begin
         mem_a  = m1_addr;
         mem_we = m1_we;
         mem_wd = m1_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_req && m1_req) state_d = last_owner_q ? OWN0 : OWN1;
            else if (m0_req)      state_d = OWN0;
            else if (m1_req)      state_d = OWN1;
         end
         OWN0: begin
            if (!m0_req)                 state_d = m1_req ? OWN1 : IDLE;
            else if (cnt_limit && m1_req) state_d = OWN1;
         end
         OWN1: begin
            if (!m1_req)                 state_d = m0_req ? OWN0 : IDLE;
            else if (cnt_limit && m0_req) state_d = OWN0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (m0_gnt)      last_owner_d = 1'b0;
      else if (m1_gnt) last_owner_d = 1'b1;
   end

   assign cnt_clear = (state_d != state_q);

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_counter (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i (cnt_clear),
      .inc_i   (m0_gnt | m1_gnt),
      .cnt_o   (burst_cnt_o),
      .limit_o (cnt_limit)
   );

   // last_owner resets to 1 so that m0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         rvalid0_q    <= m0_gnt && !m0_we;
         rvalid1_q    <= m1_gnt && !m1_we;
         if (m0_gnt && !m0_we) rdata0_q <= mem_rd;
         if (m1_gnt && !m1_we) rdata1_q <= mem_rd;
      end
   end

   assign m0_rvalid = rvalid0_q;
   assign m1_rvalid = rvalid1_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  owner_state_e state_o;
  logic [3:0]  burst_cnt_o;

  logic [31:0] mem [0:255];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int checks;
  int failures;

  dmem_arbiter #(.MAX_BURST(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .state_o(state_o), .burst_cnt_o(burst_cnt_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: synchronous write, combinational read, word indexed
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every rvalid pops one expected read
  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (exp0_q.size() == 0) check("m0_rvalid_unexpected", 1, 0);
      else check("m0_rdata", m0_rdata, exp0_q.pop_front());
    end
    if (m1_rvalid) begin
      if (exp1_q.size() == 0) check("m1_rvalid_unexpected", 1, 0);
      else check("m1_rdata", m1_rdata, exp1_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_o, IDLE);
    check({tag, "_burst"}, burst_cnt_o, 0);
    check({tag, "_gnt"}, {m1_gnt, m0_gnt}, 0);
    check({tag, "_mem"}, {mem_we, mem_a, mem_wd}, 0);
    check({tag, "_rvalid"}, {m1_rvalid, m0_rvalid}, 0);
    check({tag, "_rdata"}, {m1_rdata, m0_rdata}, 0);
  endtask

  task automatic reset_dut();
    rst = 0;
    clear_inputs();
    @(negedge clk);
    step();
    rst = 1;
  endtask

  logic [1:0] pat [13] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                           2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

  initial begin
    checks = 0;
    failures = 0;
    rst = 0;
    clear_inputs();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;  // byte address 0x10
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1;

    // single m0 read of 0x10
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk); check("rd_c1_gnt", m0_gnt, 0);
    step();
    @(negedge clk);
    check("rd_c2_gnt", m0_gnt, 1);
    check("rd_c2_mem_a", mem_a, 32'h10);
    check("rd_c2_mem_we", mem_we, 0);
    exp0_q.push_back(32'hDEADBEEF);
    step();
    m0_req = 0;
    @(negedge clk); check("rd_c3_rvalid", m0_rvalid, 1);
    step();
    @(negedge clk);
    check("rd_c4_rvalid", m0_rvalid, 0);
    check("rd_c4_rdata_hold", m0_rdata, 32'hDEADBEEF);
    check("rd_c4_state", state_o, IDLE);

    // simultaneous requests from reset: m0 first, bursts of 4
    reset_dut();
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h1234;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check($sformatf("burst_gnt_c%0d", c + 1), {m1_gnt, m0_gnt}, pat[c]);
      if (pat[c] == 2'b01) exp0_q.push_back(32'hDEADBEEF);
      if (c == 5) check("burst_m1_mem", {mem_we, mem_a, mem_wd}, {1'b1, 32'h40, 32'h1234});
      step();
    end
    clear_inputs();
    @(negedge clk);
    check("handover_withdraw_gnt", {m1_gnt, m0_gnt}, 0);
    check("handover_withdraw_state", state_o, OWN1);
    step();
    @(negedge clk); check("handover_idle", state_o, IDLE);

    // m1 writes 0x55 to 0x20, then m0 reads 0x20
    step();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    @(negedge clk); check("wr_c1_gnt", m1_gnt, 0);
    step();
    @(negedge clk);
    check("wr_c2_gnt", m1_gnt, 1);
    check("wr_c2_mem", {mem_we, mem_a, mem_wd}, {1'b1, 32'h20, 32'h55});
    step();
    clear_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    @(negedge clk); check("wr_c3_gnt", {m1_gnt, m0_gnt}, 0);
    step();
    @(negedge clk);
    check("wr_c4_gnt", m0_gnt, 1);
    exp0_q.push_back(32'h55);
    step();
    m0_req = 0;
    @(negedge clk);
    check("wr_rd_rvalid", m0_rvalid, 1);
    check("wr_no_m1_rvalid", m1_rvalid, 0);
    step();
    step();

    // m0 alone for 8 grants: counter saturates, no IDLE excursion
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk); check("sat_c1_gnt", m0_gnt, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check($sformatf("sat_gnt_%0d", i), m0_gnt, 1);
      check($sformatf("sat_state_%0d", i), state_o, OWN0);
      check($sformatf("sat_cnt_%0d", i), burst_cnt_o, (i < 4) ? i : 4);
      exp0_q.push_back(32'hDEADBEEF);
    end
    step();
    m0_req = 0;
    @(negedge clk); check("sat_end_gnt", m0_gnt, 0);
    step();
    @(negedge clk); check("sat_end_state", state_o, IDLE);

    // reset asserted one cycle after a granted read
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    step();
    @(negedge clk);
    check("rst_rd_gnt", m0_gnt, 1);
    rst = 0;
    #1;
    check_reset_outputs("rst_assert");
    @(negedge clk);
    check_reset_outputs("rst_held");
    m0_req = 0;
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_release_rvalid_%0d", i), m0_rvalid, 0);
      step();
    end

    check("exp0_q_empty", exp0_q.size(), 0);
    check("exp1_q_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive granted accesses by one owner while the other requester waits (legal range 1..15).
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have parameter DW, default 32, meaning the data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req/m1_req  input  1  access request (m0 = core load/store, m1 = debug/loader).
REQ-007 SHALL have ports m0_we/m1_we  input  1  write enable qualifying the request.
REQ-008 SHALL have ports m0_addr/m1_addr  input  AW  byte address.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  DW  write data.
REQ-010 SHALL have ports m0_gnt/m1_gnt  output  1  the access is performed this cycle.
REQ-011 SHALL have ports m0_rvalid/m1_rvalid  output  1  pulse when read data is valid.
REQ-012 SHALL have ports m0_rdata/m1_rdata  output  DW  registered read data.
REQ-013 SHALL have ports mem_a output AW, mem_we output 1, mem_wd output DW, and mem_rd input DW, connecting to data memory (synchronous write, combinational read).

Function
REQ-014 SHALL implement FSM states IDLE, OWN0 and OWN1, held in a registered owner state.
REQ-015 SHALL assert mX_gnt combinationally as (state==OWNX) && mX_req; at most one gnt high per cycle.
REQ-016 SHALL drive mem_a/mem_we/mem_wd from the granted master; with no grant, mem_we=0, mem_a=0 and mem_wd=0.
REQ-017 SHALL in IDLE: one request -> its OWN state; both -> OWN of the master not in last_owner; none -> stay IDLE (one-cycle arbitration latency).
REQ-018 SHALL in OWNX with mX_req low: other req high -> other OWN state; else IDLE.
REQ-019 SHALL count granted accesses in OWNX with burst_cnt; on the MAX_BURST-th consecutive grant, if the other req is high, next state is the other OWN state, else remain in OWNX and saturate burst_cnt.
REQ-020 SHALL clear burst_cnt on every state change; last_owner SHALL update to X on each grant to X.
REQ-021 SHALL, on a granted read (gnt && !we), register mem_rd into mX_rdata and pulse mX_rvalid for exactly one cycle on the next cycle.
REQ-022 SHALL hold mX_rdata between reads; writes SHALL produce no rvalid.
REQ-023 SHALL ignore we/addr/wdata of non-granted masters; request withdrawal in the same cycle as a state change SHALL NOT produce a grant.

Reset
REQ-024 SHALL, while rst=0 (asynchronously), force state=IDLE, last_owner=1 (so m0 wins the first tie), burst_cnt=0, all rvalid=0, all rdata=0; gnt and mem_we SHALL be 0 throughout reset.
REQ-025 SHALL discard any read in flight at reset assertion; no rvalid SHALL follow reset release.

Structure
REQ-026 SHALL place the owner-state encoding (IDLE/OWN0/OWN1) and the MAX_BURST default in the shared core package.
REQ-027 SHALL implement the burst counter plus its saturation and clear logic as one sub-module, arb_burst_counter; all other logic SHALL be in dmem_arbiter.

Verification
REQ-028 SHALL verify: m0 alone reads addr 0x10 holding 0xDEADBEEF -> gnt on cycle 2, m0_rvalid on cycle 3 with rdata 0xDEADBEEF.
REQ-029 SHALL verify: m0 and m1 request simultaneously from reset -> m0 granted first (OWN0), and m1_gnt stays 0 until the handover.
REQ-030 SHALL verify: m0 holds req for 10 cycles while m1 waits, with MAX_BURST=4 -> m0 gets exactly 4 grants, then m1 gets 4, then m0 resumes.
REQ-031 SHALL verify: m1 writes 0x55 to 0x20, then m0 reads 0x20 -> m0_rdata 0x55 and no m1_rvalid.
REQ-032 SHALL verify: rst dropped one cycle after a granted m0 read -> m0_rvalid never asserts, state returns to IDLE and all outputs are zero.
REQ-033 SHALL verify: with m0 in OWN0 and m1 idle for 8 cycles -> 8 consecutive grants with burst_cnt saturating and no IDLE excursion.
